// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared constants for the PC sequencer and the next-PC mux:
//                mux select codes, sequencer state encoding and reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Next-PC mux select codes
  localparam logic [1:0] SEL_ZERO   = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_PC4    = 2'b10;
  localparam logic [1:0] SEL_REG    = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Bus between control/imem side and the PC sequencer.
//                master : control unit / imem side (drives requests, pc_next)
//                slave  : pc_sequencer (drives pc, pc4, pc_sel, status)
//  Ports (signals):
//    stall, imem_ready, jr, jump, branch_taken, pc_next[31:0]  master -> slave
//    pc[31:0], pc4[31:0], pc_sel[1:0], fetch_valid, fault,
//    retired[CNT_W-1:0]                                        slave -> master
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             imem_ready;
  logic             jr;
  logic             jump;
  logic             branch_taken;
  logic [31:0]      pc_next;
  logic [31:0]      pc;
  logic [31:0]      pc4;
  logic [1:0]       pc_sel;
  logic             fetch_valid;
  logic             fault;
  logic [CNT_W-1:0] retired;

  modport master (
    output stall, imem_ready, jr, jump, branch_taken, pc_next,
    input  pc, pc4, pc_sel, fetch_valid, fault, retired
  );

  modport slave (
    input  stall, imem_ready, jr, jump, branch_taken, pc_next,
    output pc, pc4, pc_sel, fetch_valid, fault, retired
  );
endinterface
`default_nettype wire

// File: rtl/pc_retire_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pc_retire_counter
//  Description : Free-running count of PC advances, wraps past all-ones.
//  Ports:
//    clk    in  1      clock
//    rst_n  in  1      asynchronous active-low clear
//    en     in  1      count enable (one per PC advance)
//    count  out CNT_W  current count
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_retire_counter #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  output logic      [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (en)
      count <= count + ONE;
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter owner for the monocycle core. Selects the
//                next-PC mux input by request priority, loads the mux output
//                on an aligned advance, holds on stall / imem wait and traps
//                misaligned targets into a sticky FAULT state.
//  Ports:
//    clk    in  1   core clock (rising edge)
//    rst_n  in  1   asynchronous active-low reset
//    bus    pc_sequencer_if.slave  requests in; pc, pc4, pc_sel,
//                                  fetch_valid, fault, retired out
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input wire logic       clk,
  input wire logic       rst_n,
  pc_sequencer_if.slave  bus
);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_q;
  logic        fault_q;
  logic [1:0]  sel;
  logic        advance;
  logic        misalign;

  // Next state, mux select and advance/trap decode
  always_comb begin
    state_next = state;
    sel        = SEL_ZERO;
    advance    = 1'b0;
    misalign   = 1'b0;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        // Select tracks requests even while holding; mux output is simply
        // not loaded in that case.
        if (bus.jr)                sel = SEL_REG;
        else if (bus.jump)         sel = SEL_BRANCH;
        else if (bus.branch_taken) sel = SEL_BRANCH;
        else                       sel = SEL_PC4;
        if (bus.imem_ready && !bus.stall) begin
          if (bus.pc_next[1:0] == 2'b00) begin
            advance = 1'b1;
          end else begin
            misalign   = 1'b1;
            state_next = ST_FAULT;
          end
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state <= state_next;
      if (advance)
        pc_q <= bus.pc_next;
      if (misalign)
        fault_q <= 1'b1;
    end
  end

  pc_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (advance),
    .count (bus.retired)
  );

  assign bus.pc          = pc_q;
  assign bus.pc4         = pc_q + 32'd4;
  assign bus.pc_sel      = sel;
  assign bus.fetch_valid = (state == ST_RUN);
  assign bus.fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer. Uses a 4-bit
//                retire counter so counter wrap is reachable quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.imem_ready = 1'b0;
    bus.jr = 1'b0;
    bus.jump = 1'b0;
    bus.branch_taken = 1'b0;
    bus.pc_next = 32'h0;

    // T1: reset state, BOOT for one cycle, then RUN
    repeat (2) @(negedge clk);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_sel", {30'b0, bus.pc_sel}, 32'h0);
    check("rst_fv", {31'b0, bus.fetch_valid}, 32'h0);
    check("rst_fault", {31'b0, bus.fault}, 32'h0);
    check("rst_ret", {28'b0, bus.retired}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("boot_fv", {31'b0, bus.fetch_valid}, 32'h0);
    check("boot_sel", {30'b0, bus.pc_sel}, 32'h0);
    @(negedge clk);
    check("run_fv", {31'b0, bus.fetch_valid}, 32'h1);
    check("run_sel", {30'b0, bus.pc_sel}, 32'h2);
    check("run_pc4", bus.pc4, 32'h4);

    // T2: sequential advance 0 -> 4 -> 8 -> C -> 10
    bus.imem_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.pc_next = 32'(i * 4);
      @(negedge clk);
      check("seq_pc", bus.pc, 32'(i * 4));
    end
    check("seq_ret", {28'b0, bus.retired}, 32'd4);

    // T3: priority jr > jump > branch_taken (stalled while probing select)
    bus.stall = 1'b1;
    bus.jr = 1'b1; bus.jump = 1'b1; bus.branch_taken = 1'b1;
    #1 check("pri_jr", {30'b0, bus.pc_sel}, 32'h3);
    bus.jr = 1'b0;
    #1 check("pri_jump", {30'b0, bus.pc_sel}, 32'h1);
    bus.jump = 1'b0;
    #1 check("pri_br", {30'b0, bus.pc_sel}, 32'h1);
    bus.stall = 1'b0;
    bus.pc_next = 32'h100;
    @(negedge clk);
    check("br_pc", bus.pc, 32'h100);
    check("br_ret", {28'b0, bus.retired}, 32'd5);
    bus.branch_taken = 1'b0;

    // T4: hold on stall, on imem wait, and on both
    bus.stall = 1'b1;
    bus.pc_next = 32'h200;
    repeat (3) @(negedge clk);
    check("stall_pc", bus.pc, 32'h100);
    check("stall_ret", {28'b0, bus.retired}, 32'd5);
    check("stall_sel", {30'b0, bus.pc_sel}, 32'h2);
    bus.stall = 1'b0;
    bus.imem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_pc", bus.pc, 32'h100);
    check("wait_ret", {28'b0, bus.retired}, 32'd5);
    bus.stall = 1'b1;
    bus.pc_next = 32'h202;   // misaligned while holding: ignored
    @(negedge clk);
    check("hold_mis_fault", {31'b0, bus.fault}, 32'h0);
    check("hold_mis_fv", {31'b0, bus.fetch_valid}, 32'h1);
    check("hold_mis_pc", bus.pc, 32'h100);
    bus.stall = 1'b0;
    bus.imem_ready = 1'b1;
    bus.pc_next = 32'h200;
    @(negedge clk);
    check("rel_pc", bus.pc, 32'h200);
    check("rel_ret", {28'b0, bus.retired}, 32'd6);

    // T6: pc4 wrap and retire-counter wrap
    bus.pc_next = 32'hFFFF_FFFC;
    @(negedge clk);
    check("wrap_pc", bus.pc, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.pc4, 32'h0);
    check("wrap_ret7", {28'b0, bus.retired}, 32'd7);
    for (int i = 0; i < 8; i++) begin
      bus.pc_next = 32'h300 + 32'(i * 4);
      @(negedge clk);
    end
    check("ret_max", {28'b0, bus.retired}, 32'd15);
    bus.pc_next = 32'h320;
    @(negedge clk);
    check("ret_wrap", {28'b0, bus.retired}, 32'd0);
    check("ret_wrap_pc", bus.pc, 32'h320);

    // T5: misaligned target traps and sticks
    bus.jr = 1'b1;
    bus.pc_next = 32'h202;
    #1 check("pre_fault_sel", {30'b0, bus.pc_sel}, 32'h3);
    @(negedge clk);
    check("flt_pc", bus.pc, 32'h320);
    check("flt_fault", {31'b0, bus.fault}, 32'h1);
    check("flt_fv", {31'b0, bus.fetch_valid}, 32'h0);
    check("flt_sel", {30'b0, bus.pc_sel}, 32'h0);
    check("flt_ret", {28'b0, bus.retired}, 32'd0);
    bus.jr = 1'b0;
    bus.pc_next = 32'h400;
    repeat (3) @(negedge clk);
    check("flt_stick_pc", bus.pc, 32'h320);
    check("flt_stick", {31'b0, bus.fault}, 32'h1);

    // Asynchronous reset between edges clears everything immediately
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", bus.pc, 32'h0);
    check("arst_fault", {31'b0, bus.fault}, 32'h0);
    check("arst_fv", {31'b0, bus.fetch_valid}, 32'h0);
    check("arst_sel", {30'b0, bus.pc_sel}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.pc_next = 32'h40;
    @(negedge clk);   // BOOT -> RUN edge: no advance yet
    check("post_boot_pc", bus.pc, 32'h0);
    check("post_boot_fv", {31'b0, bus.fetch_valid}, 32'h1);
    @(negedge clk);   // second edge: first advance
    check("post_adv_pc", bus.pc, 32'h40);
    check("post_adv_ret", {28'b0, bus.retired}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
